// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divisor calculation used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Clock cycles per oversample tick, truncated.
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Never realigned to the line, so it can be shared with the transmitter.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (cnt == TOP) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling. Completed bytes are held with
// sticky ready/overrun/frame-error flags until the CPU pulses clear_i.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       clear_i,
  output logic [7:0] data_o,
  output logic       ready_o,
  output logic       overrun_o,
  output logic       frame_err_o
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam logic [3:0] SMP_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_core: CLK_FREQ too low for BAUD (DIV < 1)");
    end
  endgenerate

  logic       tick;
  logic [1:0] sync;
  logic       rx_s;
  rx_state_t  state;
  logic [3:0] sample;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       armed;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_IDLE;
      sample      <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      armed       <= 1'b0;
      data_o      <= '0;
      ready_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      // Acknowledge only acts on a pending byte; completion below overrides it.
      if (clear_i && ready_o) begin
        ready_o     <= 1'b0;
        overrun_o   <= 1'b0;
        frame_err_o <= 1'b0;
      end
      if (tick) begin
        sample <= sample + 4'd1;
        case (state)
          RX_IDLE: begin
            sample <= '0;
            // Arming is only refreshed while idle, so a line still low after
            // a frame error must go high again before a new start counts.
            if (armed && !rx_s) begin
              state <= RX_START;
              armed <= 1'b0;
            end else if (rx_s) begin
              armed <= 1'b1;
            end
          end
          RX_START: begin
            if (sample == SMP_MID) begin
              if (!rx_s) begin
                state  <= RX_DATA;
                sample <= '0;
                bitcnt <= '0;
              end else begin
                state <= RX_IDLE;
              end
            end
          end
          RX_DATA: begin
            if (sample == SMP_LAST) begin
              shreg <= {rx_s, shreg[7:1]};
              if (bitcnt == 3'd7) state  <= RX_STOP;
              else                bitcnt <= bitcnt + 3'd1;
            end
          end
          RX_STOP: begin
            if (sample == SMP_LAST) begin
              state <= RX_IDLE;
              if (rx_s) begin
                data_o    <= shreg;
                ready_o   <= 1'b1;
                overrun_o <= overrun_o | (ready_o & ~clear_i);
              end else begin
                frame_err_o <= 1'b1;
              end
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=1 (16 clocks per bit).
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       clear_i = 1'b0;
  logic [7:0] data_o;
  logic       ready_o, overrun_o, frame_err_o;

  int tests = 0;
  int fails = 0;

  uart_rx_core #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .clear_i    (clear_i),
    .data_o     (data_o),
    .ready_o    (ready_o),
    .overrun_o  (overrun_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // One 8N1 frame, 16 negedges per bit. Negedge j precedes posedge j, so the
  // stop-bit sample tick lands on posedge 154 of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int clr_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);
      rxd     = fr[j/16];
      clear_i = (j == clr_at);
      rst     = (j == rst_at);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      rxd = 1'b1; clear_i = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; clear_i = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_o); end
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    tests++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err_o); end
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(4);
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", ready_o); end
    tests++; if (data_o !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", data_o); end
    tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL basic_overrun: got %b want 0", overrun_o); end
    tests++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL basic_frame_err: got %b want 0", frame_err_o); end
    pulse_clear();
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL basic_clear_ready: got %b want 0", ready_o); end
    tests++; if (data_o !== 8'hA5) begin fails++; $display("FAIL basic_clear_data: got %h want a5", data_o); end
    idle(8);
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'h7E, 1'b1, -1, -1);
    idle(4);
    tests++; if (data_o !== 8'h7E) begin fails++; $display("FAIL overrun_data: got %h want 7e", data_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL overrun_ready: got %b want 1", ready_o); end
    tests++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", overrun_o); end
    pulse_clear();
    tests++; if ({ready_o, overrun_o} !== 2'b00) begin fails++; $display("FAIL overrun_clear: got %b want 00", {ready_o, overrun_o}); end
    idle(8);
  endtask

  task automatic test_frame_err();
    logic seen_ready;
    send_frame(8'h55, 1'b0, -1, -1);
    @(negedge clk);
    tests++; if (frame_err_o !== 1'b1) begin fails++; $display("FAIL frame_err_flag: got %b want 1", frame_err_o); end
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL frame_err_ready: got %b want 0", ready_o); end
    tests++; if (data_o !== 8'h7E) begin fails++; $display("FAIL frame_err_data: got %h want 7e", data_o); end
    // Line held low for 40 bit times: no start may be accepted meanwhile.
    seen_ready = 1'b0;
    for (int j = 0; j < 640; j++) begin
      @(negedge clk); rxd = 1'b0;
      if (ready_o) seen_ready = 1'b1;
    end
    tests++; if (seen_ready !== 1'b0) begin fails++; $display("FAIL break_ready: got %b want 0", seen_ready); end
    idle(32);
    send_frame(8'h96, 1'b1, -1, -1);
    idle(4);
    tests++; if (data_o !== 8'h96) begin fails++; $display("FAIL after_break_data: got %h want 96", data_o); end
    tests++; if ({ready_o, frame_err_o} !== 2'b11) begin fails++; $display("FAIL after_break_flags: got %b want 11", {ready_o, frame_err_o}); end
    pulse_clear();
    tests++; if ({ready_o, overrun_o, frame_err_o} !== 3'b000) begin fails++; $display("FAIL after_break_clear: got %b want 000", {ready_o, overrun_o, frame_err_o}); end
    idle(8);
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 5; j++) begin @(negedge clk); rxd = 1'b0; end
    idle(48);
    tests++; if ({ready_o, overrun_o, frame_err_o} !== 3'b000) begin fails++; $display("FAIL glitch_flags: got %b want 000", {ready_o, overrun_o, frame_err_o}); end
    send_frame(8'h81, 1'b1, -1, -1);
    idle(4);
    tests++; if (data_o !== 8'h81) begin fails++; $display("FAIL glitch_next_data: got %h want 81", data_o); end
    tests++; if ({ready_o, frame_err_o} !== 2'b10) begin fails++; $display("FAIL glitch_next_flags: got %b want 10", {ready_o, frame_err_o}); end
    pulse_clear();
    idle(8);
  endtask

  task automatic test_clear_collision();
    send_frame(8'h34, 1'b1, -1, -1);
    idle(4);
    tests++; if ({ready_o, overrun_o, data_o} !== {2'b10, 8'h34}) begin fails++; $display("FAIL pending_34: got %b %h want 10 34", {ready_o, overrun_o}, data_o); end
    send_frame(8'h12, 1'b1, 154, -1);
    idle(4);
    tests++; if (data_o !== 8'h12) begin fails++; $display("FAIL collide_data: got %h want 12", data_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL collide_ready: got %b want 1", ready_o); end
    tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL collide_overrun: got %b want 0", overrun_o); end
    // Clear landing on a frame-error stop sample.
    send_frame(8'h77, 1'b0, 154, -1);
    idle(4);
    tests++; if ({ready_o, frame_err_o} !== 2'b01) begin fails++; $display("FAIL collide_fe_flags: got %b want 01", {ready_o, frame_err_o}); end
    tests++; if (data_o !== 8'h12) begin fails++; $display("FAIL collide_fe_data: got %h want 12", data_o); end
    idle(16);
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(4);
    tests++; if ({ready_o, frame_err_o, data_o} !== {2'b11, 8'hC3}) begin fails++; $display("FAIL pre_rst: got %b %h want 11 c3", {ready_o, frame_err_o}, data_o); end
    // Reset lands mid data bit 4 (frame slot 5).
    send_frame(8'hF5, 1'b1, -1, 88);
    idle(4);
    tests++; if ({data_o, ready_o, overrun_o, frame_err_o} !== 11'h000) begin fails++; $display("FAIL midframe_rst: got %h %b want 00 000", data_o, {ready_o, overrun_o, frame_err_o}); end
    send_frame(8'hF0, 1'b1, -1, -1);
    idle(4);
    tests++; if (data_o !== 8'hF0) begin fails++; $display("FAIL post_rst_data: got %h want f0", data_o); end
    tests++; if ({ready_o, overrun_o, frame_err_o} !== 3'b100) begin fails++; $display("FAIL post_rst_flags: got %b want 100", {ready_o, overrun_o, frame_err_o}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_clear_collision();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
